mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_MAX, default 4, meaning max consecutive PCI grants while an FPGA request waits.
REQ-002 SHALL provide parameter FLAG_ADDR, default 21'h1F_FFFF, meaning PCI address decoded as host flag register, not memory.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  system clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 pci_wr_en  in  1  PCI write strobe, one cycle per word, no backpressure.
REQ-006 pci_req_addr  in  21  PCI word address.
REQ-007 pci_input_data  in  32  PCI write data.
REQ-008 rd_req  in  1  FPGA access request, held stable until rd_ready.
REQ-009 FPGA_wr_en  in  1  qualifies rd_req as write.
REQ-010 req_addr  in  21  FPGA word address.
REQ-011 write_data  in  32  FPGA write data.
REQ-012 flag_we / out_flag  in  1 / 32  FPGA status write strobe and value.
REQ-013 rd_data  out  32  FPGA read data, valid when rd_ready.
REQ-014 rd_ready  out  1  one-cycle completion pulse, reads and writes.
REQ-015 in_flag  out  32  host command register to FPGA datapath.
REQ-016 pci_status  out  32  last out_flag captured, host-readable.
REQ-017 mem_en / mem_we / mem_addr / mem_wdata  out  1/1/21/32  single-port synchronous RAM port.
REQ-018 mem_rdata  in  32  RAM read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-019 SHALL implement FSM states IDLE, FPGA_ISSUE, FPGA_WAIT; PCI writes are served in any state where the RAM port is free (IDLE, FPGA_ISSUE when deferred).
REQ-020 PCI memory write (pci_wr_en=1, addr != FLAG_ADDR) SHALL drive mem_en=1, mem_we=1 combinationally in the same cycle.
REQ-021 IDLE with rd_req=1 SHALL move to FPGA_ISSUE; FPGA_ISSUE drives mem_en=1, mem_we=FPGA_WR_en, mem_addr=req_addr unless a PCI memory write takes the port and starve count < STARVE_MAX.
REQ-022 Starve counter SHALL increment per PCI grant while in FPGA_ISSUE, clear on FPGA issue; at STARVE_MAX the FPGA issues and the concurrent PCI write is dropped and counted in an internal sticky overflow bit mirrored in pci_status[31].
REQ-023 FPGA read: FPGA_ISSUE -> FPGA_WAIT; in FPGA_WAIT rd_data=mem_rdata, rd_ready=1, return to IDLE; minimum latency rd_req to rd_ready = 2 cycles.
REQ-024 FPGA write: FPGA_ISSUE -> IDLE with rd_ready=1 in the issue cycle +1 (registered pulse); rd_data unchanged.
REQ-025 rd_req seen in IDLE the cycle after rd_ready SHALL be treated as a new request.
REQ-026 PCI write to FLAG_ADDR SHALL load in_flag next edge, no RAM access; bit 16 (start) SHALL self-clear after one cycle, other bits hold.
REQ-027 flag_we=1 SHALL load pci_status[30:0] <= out_flag[30:0] next edge; independent of PCI flag write in same cycle.
REQ-028 mem_* SHALL be 0 in cycles with no grant.

Reset
REQ-029 Reset SHALL force state IDLE, starve counter 0, rd_ready 0, rd_data 0, in_flag 0, pci_status 0; outstanding FPGA access abandoned; a still-held rd_req is re-served after reset release.

Structure
REQ-030 Package astro_mem_pkg SHALL hold ADDR_W=21, DATA_W=32, FLAG_ADDR default, START_BIT=16, arb_state_t enum.
REQ-031 Sub-module host_flag_reg SHALL contain in_flag/pci_status registers and start self-clear; FSM and RAM mux in top.

Verification
REQ-032 Idle FPGA read addr 5, RAM[5]=32'h41434143 -> rd_ready at cycle +2 with rd_data 32'h41434143.
REQ-033 PCI write 32'h00000042 to addr 0, then FPGA read addr 0 -> rd_data 32'h00000042.
REQ-034 PCI write 32'h0001_0000 to FLAG_ADDR -> in_flag=32'h0001_0000 for exactly one cycle, then 0.
REQ-035 FPGA read pending plus PCI writes every cycle -> FPGA issues after exactly 4 PCI grants, 5th PCI write dropped, pci_status[31]=1.
REQ-036 flag_we with out_flag=32'h0000_0007 simultaneous with PCI FLAG_ADDR write 32'h0000_0003 -> pci_status=7, in_flag=3.
REQ-037 rst_n low during FPGA_WAIT -> rd_ready stays 0; after release with rd_req held, read completes in 2 cycles.

Source files
------------

// File: rtl/astro_mem_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : astro_mem_pkg                                              |
// | Brief   : Shared widths, host flag defaults and arbiter state type.  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package astro_mem_pkg;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DATA_W = 32;

  // Host-side word address that maps onto the command register.
  localparam logic [ADDR_W-1:0] FLAG_ADDR_DEFAULT = 21'h1F_FFFF;

  // Command bit in in_flag that pulses for a single cycle.
  localparam int unsigned START_BIT = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FPGA_ISSUE = 2'd1,
    FPGA_WAIT  = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/host_flag_reg.sv
// +----------------------------------------------------------------------+
// | Module  : host_flag_reg                                              |
// | Brief   : Host command register (self-clearing start bit) and the    |
// |           FPGA status register with a sticky drop bit in bit 31.     |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module host_flag_reg
  import astro_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_we_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  input  logic              flag_we_i,
  input  logic [DATA_W-1:0] out_flag_i,
  input  logic              ovf_set_i,
  output logic [DATA_W-1:0] in_flag_o,
  output logic [DATA_W-1:0] pci_status_o
);

  logic [DATA_W-1:0] in_flag_q, in_flag_d;
  logic [DATA_W-2:0] status_q, status_d;
  logic              ovf_q, ovf_d;

  // Next-state: start bit drops after one cycle unless rewritten; status bit 31 is sticky.
  always_comb begin
    in_flag_d            = in_flag_q;
    in_flag_d[START_BIT] = 1'b0;
    if (host_we_i) begin
      in_flag_d = host_wdata_i;
    end
    status_d = flag_we_i ? out_flag_i[DATA_W-2:0] : status_q;
    ovf_d    = ovf_q | ovf_set_i;
  end

  // Register update with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flag_q <= '0;
      status_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      in_flag_q <= in_flag_d;
      status_q  <= status_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_flag_o    = in_flag_q;
  assign pci_status_o = {ovf_q, status_q};

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | Module  : mem_port_arbiter                                           |
// | Brief   : Shares one synchronous RAM port between un-throttled PCI   |
// |           writes and FPGA read/write requests, with a bound on how   |
// |           long PCI traffic may hold off a waiting FPGA access.       |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import astro_mem_pkg::*;
#(
  parameter int unsigned       STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0] FLAG_ADDR  = FLAG_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pci_wr_en,
  input  logic [ADDR_W-1:0] pci_req_addr,
  input  logic [DATA_W-1:0] pci_input_data,
  input  logic              rd_req,
  input  logic              FPGA_wr_en,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              flag_we,
  input  logic [DATA_W-1:0] out_flag,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ready,
  output logic [DATA_W-1:0] in_flag,
  output logic [DATA_W-1:0] pci_status,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned      CNT_W        = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              rd_ready_q, rd_ready_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              w_pci_mem_wr;
  logic              w_pci_flag_wr;
  logic              w_ovf_set;

  assign w_pci_mem_wr  = pci_wr_en && (pci_req_addr != FLAG_ADDR);
  assign w_pci_flag_wr = pci_wr_en && (pci_req_addr == FLAG_ADDR);

  // Next-state and RAM port mux: PCI owns the port by default, the FPGA overrides when it issues.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    rd_ready_d = 1'b0;
    w_ovf_set  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    // A PCI word cannot be stalled, so it takes any cycle the FPGA does not claim.
    // During FPGA_WAIT the read is already in the RAM pipeline, so the port is free.
    if (w_pci_mem_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = pci_req_addr;
      mem_wdata = pci_input_data;
    end

    case (state_q)
      IDLE: begin
        // rd_req is still held while its completion pulse is visible; it is not a new request.
        if (rd_req && !rd_ready_q) begin
          state_d = FPGA_ISSUE;
        end
      end
      FPGA_ISSUE: begin
        if (w_pci_mem_wr && (starve_q < c_starve_max)) begin
          starve_d = starve_q + 1'b1;
        end else begin
          // FPGA issues; a PCI word arriving now has lost the port and is recorded as dropped.
          w_ovf_set  = w_pci_mem_wr;
          starve_d   = '0;
          mem_en     = 1'b1;
          mem_we     = FPGA_wr_en;
          mem_addr   = req_addr;
          mem_wdata  = FPGA_wr_en ? write_data : '0;
          rd_ready_d = 1'b1;
          state_d    = FPGA_wr_en ? IDLE : FPGA_WAIT;
        end
      end
      FPGA_WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, starve count, completion pulse and held read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rd_ready_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_ready_q <= rd_ready_d;
      if (state_q == FPGA_WAIT) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  // RAM data is presented directly in the completion cycle and held afterwards.
  assign rd_data  = (state_q == FPGA_WAIT) ? mem_rdata : rd_data_q;
  assign rd_ready = rd_ready_q;

  host_flag_reg u_host_flag_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_we_i    (w_pci_flag_wr),
    .host_wdata_i (pci_input_data),
    .flag_we_i    (flag_we),
    .out_flag_i   (out_flag),
    .ovf_set_i    (w_ovf_set),
    .in_flag_o    (in_flag),
    .pci_status_o (pci_status)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | Module  : tb_mem_port_arbiter                                        |
// | Brief   : Directed scenarios plus randomized FPGA traffic under PCI  |
// |           contention, checked against a shadow memory.               |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam int unsigned STARVE_MAX = 4;
  localparam logic [20:0] FLAG_ADDR  = 21'h1F_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pci_wr_en;
  logic [20:0] pci_req_addr;
  logic [31:0] pci_input_data;
  logic        rd_req;
  logic        FPGA_wr_en;
  logic [20:0] req_addr;
  logic [31:0] write_data;
  logic        flag_we;
  logic [31:0] out_flag;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic [31:0] in_flag;
  logic [31:0] pci_status;
  logic        mem_en;
  logic        mem_we;
  logic [20:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_mem [256];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_MAX (STARVE_MAX),
    .FLAG_ADDR  (FLAG_ADDR)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pci_wr_en      (pci_wr_en),
    .pci_req_addr   (pci_req_addr),
    .pci_input_data (pci_input_data),
    .rd_req         (rd_req),
    .FPGA_wr_en     (FPGA_wr_en),
    .req_addr       (req_addr),
    .write_data     (write_data),
    .flag_we        (flag_we),
    .out_flag       (out_flag),
    .rd_data        (rd_data),
    .rd_ready       (rd_ready),
    .in_flag        (in_flag),
    .pci_status     (pci_status),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // Synchronous single-port RAM environment (256 words visible to the bench).
  logic [31:0] ram    [256];
  bit          ram_wr [256];

  function automatic logic [31:0] init_val(input int a);
    return (a == 5) ? 32'h4143_4143 : (32'hA5A5_0000 | 32'(a));
  endfunction

  function automatic logic [31:0] ram_peek(input int a);
    return ram_wr[a] ? ram[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[7:0]]    <= mem_wdata;
        ram_wr[mem_addr[7:0]] <= 1'b1;
      end else begin
        mem_rdata <= ram_peek(int'(mem_addr[7:0]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    pci_wr_en      = 1'b0;
    pci_req_addr   = '0;
    pci_input_data = '0;
    rd_req         = 1'b0;
    FPGA_wr_en     = 1'b0;
    req_addr       = '0;
    write_data     = '0;
    flag_we        = 1'b0;
    out_flag       = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    checks++; if (in_flag !== 32'h0) begin errors++; $display("FAIL reset_in_flag: got %h want 0", in_flag); end
    checks++; if (pci_status !== 32'h0) begin errors++; $display("FAIL reset_pci_status: got %h want 0", pci_status); end
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem_idle: got en=%b we=%b addr=%h wd=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_read_idle;
    int  lat;
    bit  done;
    tick();
    rd_req = 1'b1; FPGA_wr_en = 1'b0; req_addr = 21'd5;
    @(negedge clk);
    checks++; if (mem_en !== 1'b0 || rd_ready !== 1'b0) begin errors++; $display("FAIL read_idle_cycle0: got en=%b rdy=%b want 0 0", mem_en, rd_ready); end
    lat = 0; done = 0;
    while (!done && lat < 10) begin
      tick(); lat++;
      @(negedge clk);
      if (lat == 1) begin
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 21'd5) begin errors++; $display("FAIL read_idle_issue: got en=%b we=%b addr=%h want 1 0 5", mem_en, mem_we, mem_addr); end
      end
      if (rd_ready === 1'b1) done = 1;
    end
    checks++; if (!done || lat != 2) begin errors++; $display("FAIL read_idle_latency: got %0d (done=%0d) want 2", lat, done); end
    checks++; if (rd_data !== 32'h4143_4143) begin errors++; $display("FAIL read_idle_data: got %h want 41434143", rd_data); end
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    checks++; if (rd_ready !== 1'b0 || rd_data !== 32'h4143_4143) begin errors++; $display("FAIL read_idle_after: got rdy=%b data=%h want 0 41434143", rd_ready, rd_data); end
  endtask

  task automatic test_pci_then_read;
    int lat;
    bit done;
    tick();
    pci_wr_en = 1'b1; pci_req_addr = 21'd0; pci_input_data = 32'h0000_0042;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 21'd0 || mem_wdata !== 32'h42) begin errors++; $display("FAIL pci_write_port: got en=%b we=%b addr=%h wd=%h want 1 1 0 42", mem_en, mem_we, mem_addr, mem_wdata); end
    tick();
    pci_wr_en = 1'b0;
    rd_req = 1'b1; FPGA_wr_en = 1'b0; req_addr = 21'd0;
    lat = 0; done = 0;
    while (!done && lat < 10) begin
      tick(); lat++;
      @(negedge clk);
      if (rd_ready === 1'b1) done = 1;
    end
    checks++; if (!done || lat != 2 || rd_data !== 32'h42) begin errors++; $display("FAIL pci_then_read: got lat=%0d data=%h want 2 00000042", lat, rd_data); end
    tick();
    rd_req = 1'b0;
  endtask

  task automatic test_flag_start;
    tick();
    pci_wr_en = 1'b1; pci_req_addr = FLAG_ADDR; pci_input_data = 32'h0001_0000;
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL flag_no_ram: got mem_en=%b want 0", mem_en); end
    tick();
    pci_wr_en = 1'b0;
    @(negedge clk);
    checks++; if (in_flag !== 32'h0001_0000) begin errors++; $display("FAIL flag_start_set: got %h want 00010000", in_flag); end
    tick();
    @(negedge clk);
    checks++; if (in_flag !== 32'h0) begin errors++; $display("FAIL flag_start_clear: got %h want 0", in_flag); end
    pci_wr_en = 1'b1; pci_req_addr = FLAG_ADDR; pci_input_data = 32'h0001_00FF;
    tick();
    pci_wr_en = 1'b0;
    @(negedge clk);
    checks++; if (in_flag !== 32'h0001_00FF) begin errors++; $display("FAIL flag_mixed_set: got %h want 000100ff", in_flag); end
    tick();
    @(negedge clk);
    checks++; if (in_flag !== 32'h0000_00FF) begin errors++; $display("FAIL flag_mixed_hold: got %h want 000000ff", in_flag); end
  endtask

  task automatic test_flag_simul;
    tick();
    flag_we = 1'b1; out_flag = 32'h0000_0007;
    pci_wr_en = 1'b1; pci_req_addr = FLAG_ADDR; pci_input_data = 32'h0000_0003;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (pci_status !== 32'h7 || in_flag !== 32'h3) begin errors++; $display("FAIL flag_simul: got status=%h in_flag=%h want 7 3", pci_status, in_flag); end
    tick();
    flag_we = 1'b1; out_flag = 32'hFFFF_FFFF;
    tick();
    flag_we = 1'b0;
    @(negedge clk);
    checks++; if (pci_status !== 32'h7FFF_FFFF) begin errors++; $display("FAIL status_bit31_not_loaded: got %h want 7fffffff", pci_status); end
  endtask

  task automatic test_starve;
    int  k;
    int  grants;
    int  issue_k;
    tick();
    idle_inputs();
    rd_req = 1'b1; FPGA_wr_en = 1'b0; req_addr = 21'd7;
    @(negedge clk);
    checks++; if (pci_status[31] !== 1'b0) begin errors++; $display("FAIL starve_ovf_pre: got %b want 0", pci_status[31]); end
    grants = 0; issue_k = -1; k = 0;
    while (issue_k < 0 && k < 20) begin
      tick();
      pci_wr_en = 1'b1; pci_req_addr = 21'(100 + k); pci_input_data = 32'hB000_0000 + 32'(k);
      @(negedge clk);
      if (mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === 21'd7) issue_k = k;
      else if (mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === 21'(100 + k)) grants++;
      k++;
    end
    checks++; if (issue_k != STARVE_MAX || grants != STARVE_MAX) begin errors++; $display("FAIL starve_grants: got issue_at=%0d grants=%0d want %0d %0d", issue_k, grants, STARVE_MAX, STARVE_MAX); end
    tick();
    pci_wr_en = 1'b0;
    @(negedge clk);
    checks++; if (rd_ready !== 1'b1 || rd_data !== init_val(7)) begin errors++; $display("FAIL starve_read: got rdy=%b data=%h want 1 %h", rd_ready, rd_data, init_val(7)); end
    checks++; if (pci_status[31] !== 1'b1) begin errors++; $display("FAIL starve_ovf: got %b want 1", pci_status[31]); end
    checks++; if (ram_peek(103) !== 32'hB000_0003 || ram_peek(104) !== init_val(104)) begin errors++; $display("FAIL starve_drop: got ram103=%h ram104=%h want b0000003 %h", ram_peek(103), ram_peek(104), init_val(104)); end
    tick();
    rd_req = 1'b0;
  endtask

  task automatic test_reset_wait;
    int lat;
    bit done;
    tick();
    rd_req = 1'b1; FPGA_wr_en = 1'b0; req_addr = 21'd9;
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (rd_ready !== 1'b0 || pci_status !== 32'h0) begin errors++; $display("FAIL reset_wait_clear: got rdy=%b status=%h want 0 0", rd_ready, pci_status); end
    tick();
    @(negedge clk);
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_wait_hold: got rdy=%b want 0", rd_ready); end
    tick();
    rst_n = 1'b1;
    lat = 0; done = 0;
    while (!done && lat < 10) begin
      tick(); lat++;
      @(negedge clk);
      if (rd_ready === 1'b1) done = 1;
    end
    checks++; if (!done || lat != 2 || rd_data !== init_val(9)) begin errors++; $display("FAIL reset_wait_reserve: got lat=%0d data=%h want 2 %h", lat, rd_data, init_val(9)); end
    tick();
    rd_req = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] last_rd;
    last_rd = init_val(9);
    for (int t = 0; t < 150; t++) begin
      int          gap;
      int          lat;
      bit          done;
      bit          op_wr;
      int          a;
      logic [31:0] d;
      gap   = $urandom_range(0, 2);
      op_wr = 1'($urandom_range(0, 1));
      a     = $urandom_range(8, 23);
      d     = $urandom;
      for (int g = 0; g < gap; g++) begin
        tick();
        pci_wr_en = 1'b0;
        @(negedge clk);
        checks++; if (rd_ready !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL rand_gap_quiet: got rdy=%b en=%b want 0 0", rd_ready, mem_en); end
      end
      tick();
      rd_req = 1'b1; FPGA_wr_en = op_wr; req_addr = 21'(a); write_data = d;
      pci_wr_en = 1'($urandom_range(0, 1)); pci_req_addr = 21'($urandom_range(64, 95)); pci_input_data = $urandom;
      lat = 0; done = 0;
      while (!done && lat < 2 + STARVE_MAX + 4) begin
        tick(); lat++;
        pci_wr_en = 1'($urandom_range(0, 1)); pci_req_addr = 21'($urandom_range(64, 95)); pci_input_data = $urandom;
        @(negedge clk);
        if (rd_ready === 1'b1) done = 1;
      end
      checks++; if (!done || lat < 2 || lat > 2 + STARVE_MAX) begin errors++; $display("FAIL rand_latency: tx %0d got lat=%0d done=%0d want 2..%0d", t, lat, done, 2 + STARVE_MAX); end
      if (op_wr) begin
        exp_mem[a] = d;
        checks++; if (rd_data !== last_rd) begin errors++; $display("FAIL rand_wr_rd_data_held: tx %0d got %h want %h", t, rd_data, last_rd); end
      end else begin
        checks++; if (rd_data !== exp_mem[a]) begin errors++; $display("FAIL rand_read: tx %0d addr %0d got %h want %h", t, a, rd_data, exp_mem[a]); end
        last_rd = exp_mem[a];
      end
      tick();
      rd_req = 1'b0; pci_wr_en = 1'b0;
      @(negedge clk);
      checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL rand_pulse_width: tx %0d got rdy=%b want 0", t, rd_ready); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    test_reset();
    test_read_idle();
    test_pci_then_read();
    test_flag_start();
    test_flag_simul();
    test_starve();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
